mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of both requesters and memory port.
REQ-002 Parameter: DATA_W, 32, read/write data width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 reset_ni  in  1  synchronous active-low reset.
REQ-006 if_req_i  in  1  instruction-fetch read request; held high until if_ready_o.
REQ-007 if_addr_i  in  ADDR_W  fetch address.
REQ-008 if_rdata_o  out  DATA_W  fetch read data; valid while if_ready_o=1.
REQ-009 if_ready_o  out  1  one-cycle completion pulse to fetch.
REQ-010 d_req_i  in  1  data request (load or store); held high until d_ready_o.
REQ-011 d_we_i  in  1  1=store, 0=load.
REQ-012 d_addr_i / d_wdata_i  in  ADDR_W / DATA_W  data address / store data.
REQ-013 d_funct3_i  in  3  access size/sign code passed to memory.
REQ-014 d_rdata_o / d_ready_o  out  DATA_W / 1  load data; one-cycle completion pulse.
REQ-015 mem_addr_o / mem_wdata_o / mem_funct3_o  out  ADDR_W / DATA_W / 3  shared memory port.
REQ-016 mem_read_o / mem_write_o  out  1 / 1  memory strobes; never both high.
REQ-017 mem_rdata_i / mem_ready_i  in  DATA_W / 1  memory read data; completion flag.
REQ-018 stall_o  out  1  high whenever any request is pending and not yet completed.

Function
REQ-019 FSM states: IDLE, D_BUSY, I_BUSY; registered state, reset to IDLE.
REQ-020 IDLE: grant winner per REQ-026/REQ-033, latch its addr/wdata/we/funct3 into port registers, enter D_BUSY or I_BUSY next edge; no request -> stay IDLE.
REQ-021 BUSY: mem_* outputs driven only from latched registers; mem_read_o=~we, mem_write_o=we; held constant until mem_ready_i.
REQ-022 Fetch grants SHALL drive mem_funct3_o=3'b010, mem_write_o=0.
REQ-023 BUSY and mem_ready_i=1: capture mem_rdata_i into granted requester's rdata register, pulse its ready for exactly one cycle next cycle, return to IDLE; strobes low that same edge.
REQ-024 Minimum latency: request seen at edge N, strobe high cycle N+1; mem_ready_i in cycle N+1 -> ready pulse cycle N+2.
REQ-025 Requester dropping req during BUSY SHALL NOT abort the transaction; the ready pulse is still issued.
REQ-026 Fixed priority (default): simultaneous d_req_i and if_req_i in IDLE -> data granted.
REQ-027 A requester's ready SHALL NOT pulse while it is not granted; rdata_o holds last captured value between pulses.
REQ-028 stall_o = (if_req_i|d_req_i) & ~(completion pulse for every asserted req) combinationally.
REQ-029 A new request is not accepted in the cycle its previous ready pulse is high (IDLE re-arbitrates next cycle).

Reset
REQ-030 reset_ni=0 at edge: state->IDLE; all ready, mem_read_o, mem_write_o ->0; rdata and port registers ->0; last-grant ->fetch.
REQ-031 Reset mid-transaction SHALL abort it: strobes low the next cycle, no ready pulse issued, memory response ignored.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-033 Defined: simultaneous requests in IDLE -> grant the requester not granted last; last-grant register updated on every grant. Undefined: REQ-026 fixed data priority, last-grant register absent.

Verification
REQ-034 Fetch 0x00000010, mem returns 0x00500093 with ready one cycle after strobe -> if_ready_o pulse, if_rdata_o=0x00500093, funct3 3'b010.
REQ-035 Store d_addr=0x104, wdata=0xDEADBEEF, funct3=3'b010, mem_ready after 3 cycles -> mem_write_o high 3 cycles, d_ready_o one pulse, stall_o high until pulse.
REQ-036 Both req high 4 transactions, default build -> grant order D,D,D,D while d_req_i held; ARB_ROUND_ROBIN_EN -> D,I,D,I.
REQ-037 Reset asserted during D_BUSY with mem_ready_i=1 same cycle -> no d_ready_o pulse, state IDLE, d_rdata_o=0.
REQ-038 Load granted, d_req_i dropped after 1 cycle, mem_ready 2 cycles later -> d_ready_o still pulses, d_rdata_o=mem_rdata_i.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single shared memory port
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed data priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_funct3_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o
);
    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_ready_q, d_ready_q;
    logic              arb_ok, grant_d, grant_i;

    // No new grant while a completion pulse is out; the requester still holds req that cycle.
    assign arb_ok = (state_q == IDLE) & ~if_ready_q & ~d_ready_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            last_d_q <= 1'b0;
        end else if (grant_d) begin
            last_d_q <= 1'b1;
        end else if (grant_i) begin
            last_d_q <= 1'b0;
        end
    end

    always_comb begin
        grant_d = arb_ok & d_req_i & (~if_req_i | ~last_d_q);
        grant_i = arb_ok & if_req_i & ~grant_d;
    end
`else
    always_comb begin
        grant_d = arb_ok & d_req_i;
        grant_i = arb_ok & if_req_i & ~grant_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                end
            end
            D_BUSY, I_BUSY: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_ready_q <= (state_q == I_BUSY) & mem_ready_i;
            d_ready_q  <= (state_q == D_BUSY) & mem_ready_i;
            if (grant_d) begin
                addr_q   <= d_addr_i;
                wdata_q  <= d_wdata_i;
                we_q     <= d_we_i;
                funct3_q <= d_funct3_i;
            end else if (grant_i) begin
                addr_q   <= if_addr_i;
                wdata_q  <= '0;
                we_q     <= 1'b0;
                funct3_q <= 3'b010;
            end
            if ((state_q == I_BUSY) && mem_ready_i) begin
                if_rdata_q <= mem_rdata_i;
            end
            if ((state_q == D_BUSY) && mem_ready_i) begin
                d_rdata_q <= mem_rdata_i;
            end
        end
    end

    // The port is driven purely from latched registers so it cannot glitch with requester inputs.
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_funct3_o = funct3_q;
    assign mem_read_o   = (state_q != IDLE) & ~we_q;
    assign mem_write_o  = (state_q != IDLE) & we_q;

    assign if_rdata_o = if_rdata_q;
    assign if_ready_o = if_ready_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_ready_o  = d_ready_q;

    assign stall_o = (if_req_i & ~if_ready_q) | (d_req_i & ~d_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall;

    int tests_run = 0;
    int failed = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_funct3_i(d_funct3), .d_rdata_o(d_rdata), .d_ready_o(d_ready),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_funct3_o(mem_funct3),
        .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .stall_o(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        d_we = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({if_ready, d_ready, mem_read, mem_write} !== 4'b0000 || if_rdata !== 32'h0 || d_rdata !== 32'h0
            || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_outputs rdy=%b%b rw=%b%b ird=%h drd=%h addr=%h want all zero",
                     if_ready, d_ready, mem_read, mem_write, if_rdata, d_rdata, mem_addr);
        end
        tests_run++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL reset_stall got=%b want=1", stall);
        end
        do_reset();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle stall=%b rw=%b%b want 0/00", stall, mem_read, mem_write);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1 || mem_read !== 1'b0) begin
            failed++;
            $display("FAIL fetch_pre stall=%b read=%b want 1/0", stall, mem_read);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({mem_read, mem_write, mem_funct3, mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h0000_0010}) begin
            failed++;
            $display("FAIL fetch_strobe rw=%b%b f3=%b addr=%h want 10/010/00000010",
                     mem_read, mem_write, mem_funct3, mem_addr);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        tests_run++;
        if (if_ready !== 1'b0 || mem_read !== 1'b1) begin
            failed++;
            $display("FAIL fetch_wait if_ready=%b read=%b want 0/1", if_ready, mem_read);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        tests_run++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_read !== 1'b0 || stall !== 1'b0
            || d_ready !== 1'b0) begin
            failed++;
            $display("FAIL fetch_pulse if_ready=%b rdata=%h read=%b stall=%b d_ready=%b want 1/00500093/0/0/0",
                     if_ready, if_rdata, mem_read, stall, d_ready);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h0050_0093 || mem_read !== 1'b0) begin
            failed++;
            $display("FAIL fetch_after if_ready=%b rdata=%h read=%b want 0/00500093/0", if_ready, if_rdata, mem_read);
        end
    endtask

    task automatic test_store();
        int  wcnt = 0;
        int  pulses = 0;
        int  pulse_k = 0;
        bit  seen = 1'b0;
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0104; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            mem_ready = (k == 3);
            mem_rdata = 32'h0000_5A5A;
            if (seen) d_req = 1'b0;
            @(negedge clk);
            if (mem_write) begin
                wcnt++;
                tests_run++;
                if ({mem_read, mem_addr, mem_wdata, mem_funct3} !== {1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 3'b010}) begin
                    failed++;
                    $display("FAIL store_port k=%0d read=%b addr=%h wdata=%h f3=%b want 0/104/deadbeef/010",
                             k, mem_read, mem_addr, mem_wdata, mem_funct3);
                end
            end
            tests_run++;
            if (!seen && !d_ready && stall !== 1'b1) begin
                failed++;
                $display("FAIL store_stall k=%0d got=%b want=1", k, stall);
            end else if (seen && stall !== 1'b0) begin
                failed++;
                $display("FAIL store_stall_after k=%0d got=%b want=0", k, stall);
            end
            tests_run++;
            if (if_ready !== 1'b0) begin
                failed++;
                $display("FAIL store_if_ready k=%0d got=%b want=0", k, if_ready);
            end
            if (d_ready) begin
                pulses++;
                pulse_k = k;
            end
            seen = seen | d_ready;
        end
        tests_run++;
        if (wcnt != 3 || pulses != 1 || pulse_k != 4) begin
            failed++;
            $display("FAIL store_timing write_cycles=%0d pulses=%0d pulse_at=%0d want 3/1/4", wcnt, pulses, pulse_k);
        end
    endtask

    task automatic test_drop();
        int rcnt = 0;
        int pulses = 0;
        int pulse_k = 0;
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_funct3 = 3'b100;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) d_req = 1'b0;
            mem_ready = (k == 3);
            mem_rdata = (k == 3) ? 32'hCAFE_F00D : 32'h1111_1111;
            @(negedge clk);
            if (mem_read) rcnt++;
            if (d_ready) begin
                pulses++;
                pulse_k = k;
            end
        end
        tests_run++;
        if (rcnt != 3 || pulses != 1 || pulse_k != 4) begin
            failed++;
            $display("FAIL drop_timing read_cycles=%0d pulses=%0d pulse_at=%0d want 3/1/4", rcnt, pulses, pulse_k);
        end
        tests_run++;
        if (d_rdata !== 32'hCAFE_F00D) begin
            failed++;
            $display("FAIL drop_rdata got=%h want=cafef00d", d_rdata);
        end
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_funct3 = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0300) begin
            failed++;
            $display("FAIL abort_granted read=%b addr=%h want 1/00000300", mem_read, mem_addr);
        end
        @(posedge clk); #1;
        reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        reset_n = 1'b1; mem_ready = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({d_ready, mem_read, mem_write} !== 3'b000 || d_rdata !== 32'h0) begin
                failed++;
                $display("FAIL abort k=%0d d_ready=%b rw=%b%b d_rdata=%h want 0/00/0", k, d_ready, mem_read, mem_write, d_rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        int  grants[4];
        int  want[4];
        int  n = 0;
        bit  prev = 1'b0;
        bit  strobe;
`ifdef ARB_ROUND_ROBIN_EN
        want = '{2, 1, 2, 1};
`else
        want = '{2, 2, 2, 2};
`endif
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000; d_funct3 = 3'b000;
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (strobe && !prev && n < 4) begin
                grants[n] = (mem_addr[31:28] == 4'h1) ? 1 : 2;
                n++;
            end
            prev = strobe;
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tests_run++;
        if (n != 4) begin
            failed++;
            $display("FAIL priority_count grants=%0d want=4", n);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (grants[i] != want[i]) begin
                failed++;
                $display("FAIL priority_order idx=%0d got=%0d want=%0d (1=fetch 2=data)", i, grants[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        bit          if_pend = 0, d_pend = 0, d_drop = 0, saw_if = 0, saw_d = 0;
        logic [31:0] m_if_a = 0, m_d_a = 0, m_d_w = 0;
        logic        m_d_we = 0;
        logic [2:0]  m_d_f3 = 0;
        bit          p_strobe = 0, p_pulse = 0, p_ifr = 0, p_dr = 0, p_mready = 0;
        int          p_owner = 0, owner, exp_owner, last_owner = 1;
        logic [31:0] p_rdata = 0, exp_if_data = 0, exp_d_data = 0;
        bit          strobe, exp_ifp, exp_dp;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (saw_if) if_pend = 0;
            if (saw_d) begin
                d_pend = 0;
                d_drop = 0;
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                m_if_a = 32'h1000_0000 | ($urandom() & 32'h0FFF_FFFC);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                m_d_a  = 32'h2000_0000 | ($urandom() & 32'h0FFF_FFFF);
                m_d_we = 1'($urandom_range(0, 1));
                m_d_w  = $urandom();
                m_d_f3 = 3'($urandom_range(0, 7));
            end
            if_req = if_pend; if_addr = m_if_a;
            d_req = d_pend && !d_drop; d_we = m_d_we; d_addr = m_d_a; d_wdata = m_d_w; d_funct3 = m_d_f3;
            mem_ready = (mem_read | mem_write) && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom();
            @(negedge clk);
            strobe = mem_read | mem_write;
            owner = !strobe ? 0 : (mem_addr[31:28] == 4'h1) ? 1 : 2;
            tests_run++;
            if (mem_read && mem_write) begin
                failed++;
                $display("FAIL rnd_both_strobes cycle=%0d", c);
            end
            tests_run++;
            if (stall !== ((if_req & ~if_ready) | (d_req & ~d_ready))) begin
                failed++;
                $display("FAIL rnd_stall cycle=%0d got=%b reqs=%b%b rdys=%b%b", c, stall, if_req, d_req, if_ready, d_ready);
            end
            if (p_strobe) begin
                exp_owner = p_mready ? 0 : p_owner;
            end else begin
                if (p_pulse || !(p_ifr || p_dr)) exp_owner = 0;
                else if (p_ifr && p_dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                    exp_owner = (last_owner == 1) ? 2 : 1;
`else
                    exp_owner = 2;
`endif
                end else exp_owner = p_ifr ? 1 : 2;
                if (exp_owner != 0) last_owner = exp_owner;
            end
            tests_run++;
            if (owner != exp_owner) begin
                failed++;
                $display("FAIL rnd_grant cycle=%0d got=%0d want=%0d (0=none 1=fetch 2=data)", c, owner, exp_owner);
            end
            if (owner == 1) begin
                tests_run++;
                if ({mem_read, mem_write, mem_funct3, mem_addr} !== {1'b1, 1'b0, 3'b010, m_if_a}) begin
                    failed++;
                    $display("FAIL rnd_fetch_port cycle=%0d rw=%b%b f3=%b addr=%h want 10/010/%h",
                             c, mem_read, mem_write, mem_funct3, mem_addr, m_if_a);
                end
            end else if (owner == 2) begin
                tests_run++;
                if ({mem_read, mem_write, mem_funct3, mem_addr} !== {~m_d_we, m_d_we, m_d_f3, m_d_a}
                    || (m_d_we && mem_wdata !== m_d_w)) begin
                    failed++;
                    $display("FAIL rnd_data_port cycle=%0d rw=%b%b f3=%b addr=%h wdata=%h want we=%b f3=%b addr=%h wdata=%h",
                             c, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, m_d_we, m_d_f3, m_d_a, m_d_w);
                end
            end
            exp_ifp = p_strobe && p_mready && (p_owner == 1);
            exp_dp  = p_strobe && p_mready && (p_owner == 2);
            if (exp_ifp) exp_if_data = p_rdata;
            if (exp_dp) exp_d_data = p_rdata;
            tests_run++;
            if (if_ready !== exp_ifp || if_rdata !== exp_if_data) begin
                failed++;
                $display("FAIL rnd_if_resp cycle=%0d ready=%b rdata=%h want %b/%h", c, if_ready, if_rdata, exp_ifp, exp_if_data);
            end
            tests_run++;
            if (d_ready !== exp_dp || d_rdata !== exp_d_data) begin
                failed++;
                $display("FAIL rnd_d_resp cycle=%0d ready=%b rdata=%h want %b/%h", c, d_ready, d_rdata, exp_dp, exp_d_data);
            end
            p_strobe = strobe; p_owner = owner; p_mready = mem_ready; p_rdata = mem_rdata;
            p_ifr = if_req; p_dr = d_req; p_pulse = exp_ifp | exp_dp;
            saw_if = exp_ifp; saw_d = exp_dp;
            if (owner == 2 && !d_drop && $urandom_range(0, 3) == 0) d_drop = 1;
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_drop();
        test_reset_abort();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
